// File: rtl/dsp_mac_if.sv
// dsp_mac_if: operand/control and accumulator result bundle for dsp_mac_pipeline.
interface dsp_mac_if #(
    parameter int A_WIDTH   = 18,
    parameter int B_WIDTH   = 18,
    parameter int ACC_WIDTH = 48,
    parameter int CNT_WIDTH = 16
);
    logic                        CE;
    logic                        IN_VALID;
    logic signed [A_WIDTH-1:0]   A;
    logic signed [B_WIDTH-1:0]   B;
    logic                        SUB;
    logic                        CLR_ACC;
    logic                        OUT_VALID;
    logic signed [ACC_WIDTH-1:0] ACC_OUT;
    logic                        DUMP;
    logic                        CARRYOUT;
    logic                        OVF;
    logic [CNT_WIDTH-1:0]        SAMPLE_CNT;
    modport master (output CE, IN_VALID, A, B, SUB, CLR_ACC,
                    input  OUT_VALID, ACC_OUT, DUMP, CARRYOUT, OVF, SAMPLE_CNT);
    modport slave  (input  CE, IN_VALID, A, B, SUB, CLR_ACC,
                    output OUT_VALID, ACC_OUT, DUMP, CARRYOUT, OVF, SAMPLE_CNT);
endinterface

// File: rtl/dsp_mac_pipeline.sv
// dsp_mac_pipeline: 3-stage signed multiply-accumulate with add/sub, clear, auto-dump and carry/overflow flags.
module dsp_mac_pipeline #(
    parameter int A_WIDTH   = 18,
    parameter int B_WIDTH   = 18,
    parameter int ACC_WIDTH = 48,
    parameter int ACC_LEN   = 0,
    parameter int CNT_WIDTH = 16
) (
    input logic     CLK,
    input logic     RST,
    dsp_mac_if.slave bus
);
    localparam int PW = A_WIDTH + B_WIDTH;
    localparam logic [CNT_WIDTH-1:0] LEN = CNT_WIDTH'(ACC_LEN);
    logic signed [A_WIDTH-1:0]   a1_q, a1_d;
    logic signed [B_WIDTH-1:0]   b1_q, b1_d;
    logic                        sub1_q, sub1_d, clr1_q, clr1_d, v1_q, v1_d;
    logic signed [PW-1:0]        p2_q, p2_d;
    logic                        sub2_q, sub2_d, clr2_q, clr2_d, v2_q, v2_d;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;
    logic                        out_valid_q, out_valid_d, dump_q, dump_d;
    logic                        carry_q, carry_d, ovf_q, ovf_d, pend_q, pend_d;
    logic signed [ACC_WIDTH-1:0] e, t;
    logic [ACC_WIDTH:0]          sum;
    logic [CNT_WIDTH-1:0]        cnt_nx;
    logic                        restart, dump_nx, ovf_now;
    // pend_q remembers a dump across bubbles so the next valid sample restarts the sum
    always_comb begin
        a1_d        = bus.A;
        b1_d        = bus.B;
        sub1_d      = bus.SUB;
        clr1_d      = bus.CLR_ACC;
        v1_d        = bus.IN_VALID;
        p2_d        = PW'(a1_q) * PW'(b1_q);
        sub2_d      = sub1_q;
        clr2_d      = clr1_q;
        v2_d        = v1_q;
        e           = ACC_WIDTH'(p2_q);
        t           = sub2_q ? -e : e;
        restart     = clr2_q | pend_q;
        sum         = {1'b0, acc_q} + {1'b0, t};
        ovf_now     = (acc_q[ACC_WIDTH-1] == t[ACC_WIDTH-1]) && (sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
        cnt_nx      = restart ? CNT_WIDTH'(1) : cnt_q + CNT_WIDTH'(1);
        dump_nx     = (ACC_LEN != 0) && (cnt_nx == LEN);
        acc_d       = v2_q ? (restart ? t : sum[ACC_WIDTH-1:0]) : acc_q;
        cnt_d       = v2_q ? cnt_nx : cnt_q;
        carry_d     = v2_q ? (!restart && sum[ACC_WIDTH]) : carry_q;
        ovf_d       = v2_q ? (!restart && (ovf_q || ovf_now)) : ovf_q;
        dump_d      = v2_q && dump_nx;
        pend_d      = v2_q ? dump_nx : pend_q;
        out_valid_d = v2_q;
    end
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            a1_q        <= '0;
            b1_q        <= '0;
            sub1_q      <= 1'b0;
            clr1_q      <= 1'b0;
            v1_q        <= 1'b0;
            p2_q        <= '0;
            sub2_q      <= 1'b0;
            clr2_q      <= 1'b0;
            v2_q        <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            dump_q      <= 1'b0;
            pend_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (bus.CE) begin
            a1_q        <= a1_d;
            b1_q        <= b1_d;
            sub1_q      <= sub1_d;
            clr1_q      <= clr1_d;
            v1_q        <= v1_d;
            p2_q        <= p2_d;
            sub2_q      <= sub2_d;
            clr2_q      <= clr2_d;
            v2_q        <= v2_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            dump_q      <= dump_d;
            pend_q      <= pend_d;
            out_valid_q <= out_valid_d;
        end
    end
    assign bus.OUT_VALID  = out_valid_q;
    assign bus.ACC_OUT    = acc_q;
    assign bus.DUMP       = dump_q;
    assign bus.CARRYOUT   = carry_q;
    assign bus.OVF        = ovf_q;
    assign bus.SAMPLE_CNT = cnt_q;
endmodule

// File: tb/tb_dsp_mac_pipeline.sv
// tb_dsp_mac_pipeline: directed vectors for dsp_mac_pipeline with ACC_LEN = 0, 4 and 1 sharing one stimulus stream.
module tb_dsp_mac_pipeline;
    localparam logic signed [47:0] MAXP = 48'sh7FFF_FFFF_FFFF;
    localparam logic signed [47:0] MINN = 48'sh8000_0000_0000;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic ce_s, v_s, sub_s, clr_s;
    logic signed [17:0] a_s, b_s;
    int nvec = 0;
    int nerr = 0;
    dsp_mac_if bus0 ();
    dsp_mac_if bus4 ();
    dsp_mac_if bus1 ();
    assign bus0.CE = ce_s; assign bus0.IN_VALID = v_s; assign bus0.A = a_s; assign bus0.B = b_s; assign bus0.SUB = sub_s; assign bus0.CLR_ACC = clr_s;
    assign bus4.CE = ce_s; assign bus4.IN_VALID = v_s; assign bus4.A = a_s; assign bus4.B = b_s; assign bus4.SUB = sub_s; assign bus4.CLR_ACC = clr_s;
    assign bus1.CE = ce_s; assign bus1.IN_VALID = v_s; assign bus1.A = a_s; assign bus1.B = b_s; assign bus1.SUB = sub_s; assign bus1.CLR_ACC = clr_s;
    dsp_mac_pipeline #(.ACC_LEN(0)) u0 (.CLK(CLK), .RST(RST), .bus(bus0));
    dsp_mac_pipeline #(.ACC_LEN(4)) u4 (.CLK(CLK), .RST(RST), .bus(bus4));
    dsp_mac_pipeline #(.ACC_LEN(1)) u1 (.CLK(CLK), .RST(RST), .bus(bus1));
    always #5 CLK = ~CLK;

    task automatic drive(input logic ce, input logic v, input int a, input int b, input logic sub, input logic clr);
        ce_s = ce; v_s = v; a_s = 18'(a); b_s = 18'(b); sub_s = sub; clr_s = clr;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        drive(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        ce_s = 1'b1; v_s = 1'b1; a_s = 18'sd3; b_s = 18'sd4; sub_s = 1'b0; clr_s = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        nvec++; if (bus0.OUT_VALID !== 1'b0) begin nerr++; $display("FAIL rst_out_valid: got %b want 0", bus0.OUT_VALID); end
        nvec++; if (bus0.ACC_OUT !== 48'sd0) begin nerr++; $display("FAIL rst_acc: got %0d want 0", bus0.ACC_OUT); end
        nvec++; if (bus0.DUMP !== 1'b0) begin nerr++; $display("FAIL rst_dump: got %b want 0", bus0.DUMP); end
        nvec++; if (bus0.CARRYOUT !== 1'b0) begin nerr++; $display("FAIL rst_carry: got %b want 0", bus0.CARRYOUT); end
        nvec++; if (bus0.OVF !== 1'b0) begin nerr++; $display("FAIL rst_ovf: got %b want 0", bus0.OVF); end
        nvec++; if (bus0.SAMPLE_CNT !== 16'd0) begin nerr++; $display("FAIL rst_cnt: got %0d want 0", bus0.SAMPLE_CNT); end
        RST = 1'b0;
    endtask

    task automatic test_latency();
        drive(1'b1, 1'b1, 3, 4, 1'b0, 1'b1);
        nvec++; if (bus0.OUT_VALID !== 1'b0) begin nerr++; $display("FAIL lat_c1_valid: got %b want 0", bus0.OUT_VALID); end
        idle();
        nvec++; if (bus0.OUT_VALID !== 1'b0) begin nerr++; $display("FAIL lat_c2_valid: got %b want 0", bus0.OUT_VALID); end
        idle();
        nvec++; if (bus0.OUT_VALID !== 1'b1) begin nerr++; $display("FAIL lat_c3_valid: got %b want 1", bus0.OUT_VALID); end
        nvec++; if (bus0.ACC_OUT !== 48'sd12) begin nerr++; $display("FAIL lat_acc: got %0d want 12", bus0.ACC_OUT); end
        nvec++; if (bus0.SAMPLE_CNT !== 16'd1) begin nerr++; $display("FAIL lat_cnt: got %0d want 1", bus0.SAMPLE_CNT); end
        idle();
        nvec++; if (bus0.OUT_VALID !== 1'b0) begin nerr++; $display("FAIL lat_c4_valid: got %b want 0", bus0.OUT_VALID); end
    endtask

    task automatic test_accumulate();
        drive(1'b1, 1'b1, 3, 4, 1'b0, 1'b1);
        drive(1'b1, 1'b1, -2, 5, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 7, 7, 1'b1, 1'b0);
        nvec++; if (bus0.ACC_OUT !== 48'sd12 || bus0.SAMPLE_CNT !== 16'd1) begin nerr++; $display("FAIL acc_s1: got %0d/%0d want 12/1", bus0.ACC_OUT, bus0.SAMPLE_CNT); end
        idle();
        nvec++; if (bus0.ACC_OUT !== 48'sd2 || bus0.SAMPLE_CNT !== 16'd2) begin nerr++; $display("FAIL acc_s2: got %0d/%0d want 2/2", bus0.ACC_OUT, bus0.SAMPLE_CNT); end
        nvec++; if (bus0.CARRYOUT !== 1'b1) begin nerr++; $display("FAIL acc_s2_carry: got %b want 1", bus0.CARRYOUT); end
        idle();
        nvec++; if (bus0.ACC_OUT !== -48'sd47 || bus0.SAMPLE_CNT !== 16'd3) begin nerr++; $display("FAIL acc_s3: got %0d/%0d want -47/3", bus0.ACC_OUT, bus0.SAMPLE_CNT); end
        nvec++; if (bus0.CARRYOUT !== 1'b0 || bus0.OVF !== 1'b0) begin nerr++; $display("FAIL acc_s3_flags: got c=%b o=%b want c=0 o=0", bus0.CARRYOUT, bus0.OVF); end
        idle();
        nvec++; if (bus0.OUT_VALID !== 1'b0 || bus0.ACC_OUT !== -48'sd47) begin nerr++; $display("FAIL acc_hold: got v=%b acc=%0d want v=0 acc=-47", bus0.OUT_VALID, bus0.ACC_OUT); end
    endtask

    task automatic test_ce_bubbles();
        drive(1'b1, 1'b1, 3, 4, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 9, 9, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 9, 9, 1'b0, 1'b0);
        nvec++; if (bus0.OUT_VALID !== 1'b0) begin nerr++; $display("FAIL ce_low_valid: got %b want 0", bus0.OUT_VALID); end
        drive(1'b1, 1'b1, -2, 5, 1'b0, 1'b0);
        nvec++; if (bus0.OUT_VALID !== 1'b0) begin nerr++; $display("FAIL ce_c4_valid: got %b want 0", bus0.OUT_VALID); end
        drive(1'b1, 1'b0, 9, 9, 1'b1, 1'b1);
        nvec++; if (bus0.OUT_VALID !== 1'b1 || bus0.ACC_OUT !== 48'sd12) begin nerr++; $display("FAIL ce_s1: got v=%b acc=%0d want v=1 acc=12", bus0.OUT_VALID, bus0.ACC_OUT); end
        drive(1'b0, 1'b1, 9, 9, 1'b1, 1'b1);
        nvec++; if (bus0.OUT_VALID !== 1'b1 || bus0.ACC_OUT !== 48'sd12) begin nerr++; $display("FAIL ce_hold: got v=%b acc=%0d want v=1 acc=12", bus0.OUT_VALID, bus0.ACC_OUT); end
        drive(1'b1, 1'b1, 7, 7, 1'b1, 1'b0);
        nvec++; if (bus0.ACC_OUT !== 48'sd2 || bus0.SAMPLE_CNT !== 16'd2) begin nerr++; $display("FAIL ce_s2: got %0d/%0d want 2/2", bus0.ACC_OUT, bus0.SAMPLE_CNT); end
        idle();
        nvec++; if (bus0.OUT_VALID !== 1'b0 || bus0.ACC_OUT !== 48'sd2) begin nerr++; $display("FAIL ce_bubble: got v=%b acc=%0d want v=0 acc=2", bus0.OUT_VALID, bus0.ACC_OUT); end
        idle();
        nvec++; if (bus0.OUT_VALID !== 1'b1 || bus0.ACC_OUT !== -48'sd47 || bus0.SAMPLE_CNT !== 16'd3) begin nerr++; $display("FAIL ce_s3: got v=%b acc=%0d cnt=%0d want v=1 acc=-47 cnt=3", bus0.OUT_VALID, bus0.ACC_OUT, bus0.SAMPLE_CNT); end
        idle();
    endtask

    task automatic test_auto_dump();
        for (int i = 0; i <= 10; i++) begin
            if (i < 8) drive(1'b1, 1'b1, 1, 1, 1'b0, i == 0);
            else idle();
            if (i >= 2 && i <= 9) begin
                int k;
                logic signed [47:0] want;
                k = i - 1;
                want = 48'((k - 1) % 4 + 1);
                nvec++; if (bus4.OUT_VALID !== 1'b1 || bus4.ACC_OUT !== want || bus4.SAMPLE_CNT !== 16'(want)) begin nerr++; $display("FAIL dump4_s%0d: got v=%b acc=%0d cnt=%0d want v=1 acc=%0d cnt=%0d", k, bus4.OUT_VALID, bus4.ACC_OUT, bus4.SAMPLE_CNT, want, want); end
                nvec++; if (bus4.DUMP !== (k % 4 == 0)) begin nerr++; $display("FAIL dump4_flag_s%0d: got %b want %b", k, bus4.DUMP, k % 4 == 0); end
                nvec++; if (bus1.DUMP !== 1'b1 || bus1.ACC_OUT !== 48'sd1 || bus1.SAMPLE_CNT !== 16'd1) begin nerr++; $display("FAIL dump1_s%0d: got d=%b acc=%0d cnt=%0d want d=1 acc=1 cnt=1", k, bus1.DUMP, bus1.ACC_OUT, bus1.SAMPLE_CNT); end
            end
            if (i == 10) begin
                nvec++; if (bus4.OUT_VALID !== 1'b0 || bus4.DUMP !== 1'b0) begin nerr++; $display("FAIL dump4_idle: got v=%b d=%b want v=0 d=0", bus4.OUT_VALID, bus4.DUMP); end
            end
        end
    endtask

    task automatic test_dump_edge();
        int sa [9] = '{2, 2, 2, 2, 0, 1, 1, 1, 1};
        int sb [9] = '{3, 3, 3, 3, 0, 1, 1, 1, 1};
        int sv [9] = '{1, 1, 1, 1, 0, 1, 1, 1, 1};
        int sc [9] = '{1, 0, 0, 0, 0, 0, 0, 0, 1};
        for (int i = 0; i <= 10; i++) begin
            if (i < 9) drive(1'b1, sv[i] != 0, sa[i], sb[i], 1'b0, sc[i] != 0);
            else idle();
            if (i == 5) begin
                nvec++; if (bus4.ACC_OUT !== 48'sd24 || bus4.SAMPLE_CNT !== 16'd4 || bus4.DUMP !== 1'b1) begin nerr++; $display("FAIL edge_dump: got acc=%0d cnt=%0d d=%b want 24/4/1", bus4.ACC_OUT, bus4.SAMPLE_CNT, bus4.DUMP); end
            end
            if (i == 6) begin
                nvec++; if (bus4.OUT_VALID !== 1'b0 || bus4.DUMP !== 1'b0 || bus4.ACC_OUT !== 48'sd24) begin nerr++; $display("FAIL edge_bubble: got v=%b d=%b acc=%0d want 0/0/24", bus4.OUT_VALID, bus4.DUMP, bus4.ACC_OUT); end
            end
            if (i == 7) begin
                nvec++; if (bus4.ACC_OUT !== 48'sd1 || bus4.SAMPLE_CNT !== 16'd1 || bus4.DUMP !== 1'b0) begin nerr++; $display("FAIL edge_restart: got acc=%0d cnt=%0d d=%b want 1/1/0", bus4.ACC_OUT, bus4.SAMPLE_CNT, bus4.DUMP); end
            end
            if (i == 9) begin
                nvec++; if (bus4.ACC_OUT !== 48'sd3 || bus4.SAMPLE_CNT !== 16'd3) begin nerr++; $display("FAIL edge_s3: got acc=%0d cnt=%0d want 3/3", bus4.ACC_OUT, bus4.SAMPLE_CNT); end
            end
            if (i == 10) begin
                nvec++; if (bus4.ACC_OUT !== 48'sd1 || bus4.SAMPLE_CNT !== 16'd1 || bus4.DUMP !== 1'b0) begin nerr++; $display("FAIL edge_clr_nth: got acc=%0d cnt=%0d d=%b want 1/1/0", bus4.ACC_OUT, bus4.SAMPLE_CNT, bus4.DUMP); end
                nvec++; if (bus1.DUMP !== 1'b1 || bus1.ACC_OUT !== 48'sd1) begin nerr++; $display("FAIL edge_len1: got d=%b acc=%0d want 1/1", bus1.DUMP, bus1.ACC_OUT); end
            end
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i <= 8198; i++) begin
            if (i <= 8190) drive(1'b1, 1'b1, -131072, -131072, 1'b0, i == 0);
            else if (i == 8191) drive(1'b1, 1'b1, 131071, 131071, 1'b0, 1'b0);
            else if (i == 8192) drive(1'b1, 1'b1, 131071, 2, 1'b0, 1'b0);
            else if (i <= 8194) drive(1'b1, 1'b1, 1, 1, 1'b0, 1'b0);
            else if (i == 8195) drive(1'b1, 1'b1, 5, 1, 1'b0, 1'b1);
            else if (i == 8196) drive(1'b1, 1'b1, -1, 1, 1'b0, 1'b0);
            else idle();
            if (i == 8194) begin
                nvec++; if (bus0.ACC_OUT !== MAXP || bus0.OVF !== 1'b0) begin nerr++; $display("FAIL ovf_max: got acc=%0d o=%b want %0d/0", bus0.ACC_OUT, bus0.OVF, MAXP); end
            end
            if (i == 8195) begin
                nvec++; if (bus0.ACC_OUT !== MINN || bus0.OVF !== 1'b1 || bus0.CARRYOUT !== 1'b0) begin nerr++; $display("FAIL ovf_wrap: got acc=%0d o=%b c=%b want %0d/1/0", bus0.ACC_OUT, bus0.OVF, bus0.CARRYOUT, MINN); end
            end
            if (i == 8196) begin
                nvec++; if (bus0.ACC_OUT !== MINN + 48'sd1 || bus0.OVF !== 1'b1) begin nerr++; $display("FAIL ovf_sticky: got acc=%0d o=%b want %0d/1", bus0.ACC_OUT, bus0.OVF, MINN + 48'sd1); end
            end
            if (i == 8197) begin
                nvec++; if (bus0.ACC_OUT !== 48'sd5 || bus0.OVF !== 1'b0 || bus0.CARRYOUT !== 1'b0) begin nerr++; $display("FAIL ovf_clr: got acc=%0d o=%b c=%b want 5/0/0", bus0.ACC_OUT, bus0.OVF, bus0.CARRYOUT); end
            end
            if (i == 8198) begin
                nvec++; if (bus0.ACC_OUT !== 48'sd4 || bus0.CARRYOUT !== 1'b1 || bus0.OVF !== 1'b0) begin nerr++; $display("FAIL carry_neg1: got acc=%0d c=%b o=%b want 4/1/0", bus0.ACC_OUT, bus0.CARRYOUT, bus0.OVF); end
            end
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 1'b1, 3, 4, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1, 1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 2, 2, 1'b0, 1'b0);
        nvec++; if (bus0.OUT_VALID !== 1'b1 || bus0.ACC_OUT !== 48'sd12) begin nerr++; $display("FAIL arst_pre: got v=%b acc=%0d want 1/12", bus0.OUT_VALID, bus0.ACC_OUT); end
        v_s = 1'b0;
        #2;
        RST = 1'b1;
        #1;
        nvec++; if (bus0.OUT_VALID !== 1'b0 || bus0.ACC_OUT !== 48'sd0 || bus0.SAMPLE_CNT !== 16'd0) begin nerr++; $display("FAIL arst_now: got v=%b acc=%0d cnt=%0d want 0/0/0", bus0.OUT_VALID, bus0.ACC_OUT, bus0.SAMPLE_CNT); end
        nvec++; if (bus4.ACC_OUT !== 48'sd0 || bus4.SAMPLE_CNT !== 16'd0) begin nerr++; $display("FAIL arst_now4: got acc=%0d cnt=%0d want 0/0", bus4.ACC_OUT, bus4.SAMPLE_CNT); end
        @(posedge CLK);
        #3;
        RST = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idle();
            nvec++; if (bus0.OUT_VALID !== 1'b0) begin nerr++; $display("FAIL arst_flush%0d: got %b want 0", i, bus0.OUT_VALID); end
        end
        drive(1'b1, 1'b1, 6, 7, 1'b0, 1'b0);
        idle();
        idle();
        nvec++; if (bus0.OUT_VALID !== 1'b1 || bus0.ACC_OUT !== 48'sd42 || bus0.SAMPLE_CNT !== 16'd1) begin nerr++; $display("FAIL arst_after: got v=%b acc=%0d cnt=%0d want 1/42/1", bus0.OUT_VALID, bus0.ACC_OUT, bus0.SAMPLE_CNT); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_accumulate();
        test_ce_bubbles();
        test_auto_dump();
        test_dump_edge();
        test_overflow();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
